// File: rtl/peripheral_qos_arbiter_wb.sv
// peripheral_qos_arbiter_wb
// Weighted round-robin Wishbone B3 arbiter: NUM_MASTERS master ports share one
// slave port. Ownership spans a whole Wishbone cycle (cyc high to cyc low).
// Each master has a burst quota (WEIGHTS) and there is a bus-hang watchdog.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbm_*_i                 packed per-master request fields (master 0 in LSBs)
//   wbm_dat_o               slave read data, broadcast to every master
//   wbm_ack/err/rty_o       responses, only the owner's bit is ever set
//   wbs_*_o                 owner's request fields routed to the slave
//   wbs_dat/ack/err/rty_i   slave responses
//   grant_o                 registered one-hot owner
//   timeout_o               one-cycle pulse when the watchdog terminates a cycle
module peripheral_qos_arbiter_wb #(
   parameter int unsigned              NUM_MASTERS = 4,
   parameter int unsigned              AW          = 32,
   parameter int unsigned              DW          = 32,
   parameter logic [4*NUM_MASTERS-1:0] WEIGHTS     = {NUM_MASTERS{4'd1}},
   parameter int unsigned              TIMEOUT     = 255
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_i,
   input  logic [NUM_MASTERS*AW-1:0]       wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]       wbm_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0]   wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]          wbm_we_i,
   input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]        wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]        wbm_bte_i,
   output logic [DW-1:0]                   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]          wbm_ack_o,
   output logic [NUM_MASTERS-1:0]          wbm_err_o,
   output logic [NUM_MASTERS-1:0]          wbm_rty_o,
   output logic [AW-1:0]                   wbs_adr_o,
   output logic [DW-1:0]                   wbs_dat_o,
   output logic [DW/8-1:0]                 wbs_sel_o,
   output logic                            wbs_we_o,
   output logic                            wbs_cyc_o,
   output logic                            wbs_stb_o,
   output logic [2:0]                      wbs_cti_o,
   output logic [1:0]                      wbs_bte_o,
   input  logic [DW-1:0]                   wbs_dat_i,
   input  logic                            wbs_ack_i,
   input  logic                            wbs_err_i,
   input  logic                            wbs_rty_i,
   output logic [NUM_MASTERS-1:0]          grant_o,
   output logic                            timeout_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          WD_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0]          CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [NUM_MASTERS-1:0] GRANT_LSB = NUM_MASTERS'(1);
   localparam logic [IW-1:0]          OWNER_RST = IW'(NUM_MASTERS - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                   state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   // Current owner while BUSY, last owner while IDLE.
   logic [IW-1:0]            owner_q, owner_d;
   logic [3:0]               credit_q [NUM_MASTERS];
   logic [3:0]               credit_d [NUM_MASTERS];
   logic [CW-1:0]            wd_cnt_q, wd_cnt_d;

   logic [AW-1:0]            m_adr [NUM_MASTERS];
   logic [DW-1:0]            m_dat [NUM_MASTERS];
   logic [SW-1:0]            m_sel [NUM_MASTERS];
   logic [2:0]               m_cti [NUM_MASTERS];
   logic [1:0]               m_bte [NUM_MASTERS];
   logic [3:0]               reload [NUM_MASTERS];

   logic                     busy;
   logic                     own_cyc;
   logic                     own_stb;
   logic                     rsp_any;
   logic                     stall;
   logic                     wd_fire;

   logic                     win_found;
   logic                     win_reuse;
   logic [IW-1:0]            win_idx;
   logic [IW-1:0]            cand;

   // Unpack per-master fields; reload value is weight-1 with weight 0 treated as 1.
   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign m_adr[g]  = wbm_adr_i[g*AW +: AW];
      assign m_dat[g]  = wbm_dat_i[g*DW +: DW];
      assign m_sel[g]  = wbm_sel_i[g*SW +: SW];
      assign m_cti[g]  = wbm_cti_i[g*3 +: 3];
      assign m_bte[g]  = wbm_bte_i[g*2 +: 2];
      assign reload[g] = (WEIGHTS[g*4 +: 4] == 4'd0) ? 4'd0 : WEIGHTS[g*4 +: 4] - 4'd1;
   end

   assign busy    = (state_q == BUSY);
   assign own_cyc = busy & wbm_cyc_i[owner_q];
   assign own_stb = busy & wbm_stb_i[owner_q];
   assign rsp_any = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // Stall is judged on the unforced strobe so the firing cycle still counts.
   assign stall   = own_stb & ~rsp_any;
   // Fires on the stalled cycle that would bring the count to TIMEOUT; any response wins.
   assign wd_fire = WD_EN && stall && (wd_cnt_q == CNT_LAST);

   // Slave-side routing follows the registered grant, so reset clears it at once.
   assign wbs_adr_o = busy ? m_adr[owner_q] : '0;
   assign wbs_dat_o = busy ? m_dat[owner_q] : '0;
   assign wbs_sel_o = busy ? m_sel[owner_q] : '0;
   assign wbs_we_o  = busy & wbm_we_i[owner_q];
   assign wbs_cti_o = busy ? m_cti[owner_q] : 3'b000;
   assign wbs_bte_o = busy ? m_bte[owner_q] : 2'b00;
   assign wbs_cyc_o = own_cyc & ~wd_fire;
   assign wbs_stb_o = own_stb & ~wd_fire;

   // Responses reach the owner's bit only; grant_q is zero outside BUSY.
   assign wbm_dat_o = wbs_dat_i;
   assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
   assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | wd_fire}};
   assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
   assign grant_o   = grant_q;
   assign timeout_o = wd_fire;

   // Next-state, arbitration and watchdog logic.
   always_comb begin : next_state
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      credit_d  = credit_q;
      wd_cnt_d  = wd_cnt_q;
      win_found = 1'b0;
      win_reuse = 1'b0;
      win_idx   = owner_q;
      cand      = '0;

      // Last owner keeps the bus while it still has quota; otherwise round-robin.
      if (wbm_cyc_i[owner_q] && (credit_q[owner_q] != 4'd0)) begin
         win_found = 1'b1;
         win_reuse = 1'b1;
         win_idx   = owner_q;
      end else begin
         for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            cand = IW'((int'(owner_q) + k) % int'(NUM_MASTERS));
            if (!win_found && wbm_cyc_i[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = BUSY;
               grant_d = GRANT_LSB << win_idx;
               owner_d = win_idx;
               if (win_reuse) begin
                  credit_d[win_idx] = credit_q[win_idx] - 4'd1;
               end else begin
                  credit_d[win_idx] = reload[win_idx];
               end
            end
         end
         BUSY: begin
            if (!wbm_cyc_i[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      if (!WD_EN || !own_cyc || rsp_any || wd_fire) begin
         wd_cnt_d = '0;
      end else if (stall) begin
         wd_cnt_d = wd_cnt_q + CW'(1);
      end
   end

   // State register; last owner resets to NUM_MASTERS-1 so master 0 is scanned first.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin : regs
      if (wb_rst_i) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         owner_q  <= OWNER_RST;
         wd_cnt_q <= '0;
         for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            credit_q[i] <= 4'd0;
         end
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         wd_cnt_q <= wd_cnt_d;
         credit_q <= credit_d;
      end
   end

endmodule

// File: tb/tb_peripheral_qos_arbiter_wb.sv
// tb_peripheral_qos_arbiter_wb
// Self-checking bench for peripheral_qos_arbiter_wb. Instance a uses unit weights
// with TIMEOUT=4; instance b uses WEIGHTS={1,1,1,3} with the watchdog disabled.
// Expected grants are queued when stimulus is applied and popped on each new grant.
module tb_peripheral_qos_arbiter_wb;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic               clk;
   logic               rst;
   logic [NM*AW-1:0]   m_adr;
   logic [NM*DW-1:0]   m_dat;
   logic [NM*4-1:0]    m_sel;
   logic [NM-1:0]      m_we, m_cyc, m_stb;
   logic [NM*3-1:0]    m_cti;
   logic [NM*2-1:0]    m_bte;
   logic [DW-1:0]      s_dat;
   logic               ack_drv, s_err, s_rty, sel_w;
   logic               a_ack_in, b_ack_in;

   logic [DW-1:0]      a_rdat, b_rdat, a_wdat, b_wdat;
   logic [NM-1:0]      a_ack, a_err, a_rty, b_ack, b_err, b_rty, a_grant, b_grant;
   logic [AW-1:0]      a_adr, b_adr;
   logic [3:0]         a_sel, b_sel;
   logic               a_we, a_cyc, a_stb, b_we, b_cyc, b_stb, a_to, b_to;
   logic [2:0]         a_cti, b_cti;
   logic [1:0]         a_bte, b_bte;

   logic [NM-1:0]      obs_grant, obs_ack;
   logic               obs_stb;

   int                 total;
   int                 bad;
   logic [NM-1:0]      exp_q [$];

   assign a_ack_in  = ack_drv & ~sel_w;
   assign b_ack_in  = ack_drv & sel_w;
   assign obs_grant = sel_w ? b_grant : a_grant;
   assign obs_ack   = sel_w ? b_ack : a_ack;
   assign obs_stb   = sel_w ? b_stb : a_stb;

   peripheral_qos_arbiter_wb #(
      .NUM_MASTERS(NM), .AW(AW), .DW(DW),
      .WEIGHTS({4'd1, 4'd1, 4'd1, 4'd1}), .TIMEOUT(4)
   ) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
      .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
      .wbm_dat_o(a_rdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
      .wbs_adr_o(a_adr), .wbs_dat_o(a_wdat), .wbs_sel_o(a_sel), .wbs_we_o(a_we),
      .wbs_cyc_o(a_cyc), .wbs_stb_o(a_stb), .wbs_cti_o(a_cti), .wbs_bte_o(a_bte),
      .wbs_dat_i(s_dat), .wbs_ack_i(a_ack_in), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .grant_o(a_grant), .timeout_o(a_to)
   );

   peripheral_qos_arbiter_wb #(
      .NUM_MASTERS(NM), .AW(AW), .DW(DW),
      .WEIGHTS({4'd1, 4'd1, 4'd1, 4'd3}), .TIMEOUT(0)
   ) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
      .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
      .wbm_dat_o(b_rdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
      .wbs_adr_o(b_adr), .wbs_dat_o(b_wdat), .wbs_sel_o(b_sel), .wbs_we_o(b_we),
      .wbs_cyc_o(b_cyc), .wbs_stb_o(b_stb), .wbs_cti_o(b_cti), .wbs_bte_o(b_bte),
      .wbs_dat_i(s_dat), .wbs_ack_i(b_ack_in), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .grant_o(b_grant), .timeout_o(b_to)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0;
      ack_drv = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; m_cyc = '0; m_stb = '0; ack_drv = 1'b1;
      #2;
      total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", a_grant); end
      total++; if (a_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b exp=0", a_cyc); end
      total++; if (a_to !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", a_to); end
      total++; if (a_ack !== 4'b0000) begin bad++; $display("FAIL rst_ack got=%b exp=0000", a_ack); end
      ack_drv = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick(); #1;
      total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL idle_grant got=%b exp=0000", a_grant); end
   endtask

   task automatic test_single();
      logic [NM-1:0] e;
      do_reset();
      sel_w = 1'b0;
      m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
      exp_q.push_back(4'b0100);
      tick(); #1;
      e = exp_q.pop_front();
      total++; if (a_grant !== e) begin bad++; $display("FAIL single_grant got=%b exp=%b", a_grant, e); end
      total++; if (a_cyc !== 1'b1) begin bad++; $display("FAIL single_cyc got=%b exp=1", a_cyc); end
      total++; if (a_adr !== 32'h1000_0200) begin bad++; $display("FAIL single_adr got=%h exp=10000200", a_adr); end
      total++; if (a_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", a_we); end
      total++; if (a_ack !== 4'b0000) begin bad++; $display("FAIL single_noack got=%b exp=0000", a_ack); end
      tick();
      ack_drv = 1'b1; s_dat = 32'hCAFE_0002;
      #1;
      total++; if (a_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", a_ack); end
      total++; if (a_rdat !== 32'hCAFE_0002) begin bad++; $display("FAIL single_rdat got=%h exp=cafe0002", a_rdat); end
      tick();
      m_cyc = '0; m_stb = '0; m_we = '0; ack_drv = 1'b0;
      tick(); #1;
      total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", a_grant); end
   endtask

   // Masters in mask issue single-beat cycles back to back; a slave acks every strobe.
   task automatic run_stream(input logic [NM-1:0] mask, input bit chk_gap, input string tag);
      logic [NM-1:0] ackseen, prev_g, e;
      int gap, ngrant;
      ackseen = '0; prev_g = '0; gap = 0; ngrant = 0;
      m_cyc = mask; m_stb = mask;
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
         tick();
         for (int i = 0; i < int'(NM); i++) begin
            if (ackseen[i]) begin
               m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            end else if (mask[i]) begin
               m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
            end
         end
         ack_drv = 1'b0;
         #1 ack_drv = obs_stb;
         #1;
         ackseen = obs_ack;
         if (obs_grant != 4'b0000 && prev_g == 4'b0000) begin
            e = exp_q.pop_front();
            total++; if (obs_grant !== e) begin bad++; $display("FAIL %s_grant#%0d got=%b exp=%b", tag, ngrant, obs_grant, e); end
            if (chk_gap && ngrant > 0) begin
               total++; if (gap !== 1) begin bad++; $display("FAIL %s_gap#%0d got=%0d exp=1", tag, ngrant, gap); end
            end
            ngrant++;
            gap = 0;
         end else if (obs_grant == 4'b0000) begin
            gap++;
         end
         prev_g = obs_grant;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL %s_stall got=%0d grants exp=%0d more", tag, ngrant, exp_q.size());
         exp_q.delete();
      end
      m_cyc = '0; m_stb = '0; ack_drv = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      sel_w = 1'b0;
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
      run_stream(4'b1111, 1'b1, "rr");
   endtask

   task automatic test_weighting();
      do_reset();
      sel_w = 1'b1;
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
         exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      end
      run_stream(4'b0011, 1'b0, "wrr");
      sel_w = 1'b0;
   endtask

   task automatic test_watchdog();
      logic [NM-1:0] e, e_err;
      int pulses;
      bit got;
      do_reset();
      sel_w = 1'b0;
      m_cyc = 4'b1010; m_stb = 4'b1010;
      exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
      tick(); #1;
      e = exp_q.pop_front();
      total++; if (a_grant !== e) begin bad++; $display("FAIL wd_grant got=%b exp=%b", a_grant, e); end
      pulses = 0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin tick(); #1; end
         if (a_to) pulses++;
         e_err = (k == 4) ? 4'b0010 : 4'b0000;
         total++; if (a_err !== e_err) begin bad++; $display("FAIL wd_err#%0d got=%b exp=%b", k, a_err, e_err); end
         total++; if (a_cyc !== (k != 4)) begin bad++; $display("FAIL wd_cyc#%0d got=%b exp=%b", k, a_cyc, (k != 4)); end
      end
      tick();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      #1;
      if (a_to) pulses++;
      total++; if (pulses !== 1) begin bad++; $display("FAIL wd_pulses got=%0d exp=1", pulses); end
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick(); #1;
         if (a_grant != 4'b0000 && a_grant != 4'b0010) got = 1'b1;
      end
      e = exp_q.pop_front();
      total++; if (a_grant !== e) begin bad++; $display("FAIL wd_next_grant got=%b exp=%b", a_grant, e); end
      m_cyc = '0; m_stb = '0;
      repeat (3) tick();
   endtask

   task automatic test_collision();
      do_reset();
      sel_w = 1'b0;
      m_cyc = 4'b0001; m_stb = 4'b0001;
      tick(); #1;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         ack_drv = (k == 4);
         #1;
      end
      total++; if (a_ack !== 4'b0001) begin bad++; $display("FAIL col_ack got=%b exp=0001", a_ack); end
      total++; if (a_err !== 4'b0000) begin bad++; $display("FAIL col_err got=%b exp=0000", a_err); end
      total++; if (a_to !== 1'b0) begin bad++; $display("FAIL col_timeout got=%b exp=0", a_to); end
      tick();
      m_cyc = '0; m_stb = '0; ack_drv = 1'b0;
      #1;
      total++; if (a_err !== 4'b0000) begin bad++; $display("FAIL col_after_err got=%b exp=0000", a_err); end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      logic [NM-1:0] e;
      do_reset();
      sel_w = 1'b0;
      m_cyc = 4'b0010; m_stb = 4'b0010;
      exp_q.push_back(4'b0010);
      tick(); #1;
      e = exp_q.pop_front();
      total++; if (a_grant !== e) begin bad++; $display("FAIL mrst_own got=%b exp=%b", a_grant, e); end
      tick();
      rst = 1'b1; ack_drv = 1'b1;
      #1;
      total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL mrst_grant got=%b exp=0000", a_grant); end
      total++; if (a_cyc !== 1'b0) begin bad++; $display("FAIL mrst_cyc got=%b exp=0", a_cyc); end
      total++; if (a_ack !== 4'b0000) begin bad++; $display("FAIL mrst_ack got=%b exp=0000", a_ack); end
      m_cyc = 4'b1010; m_stb = 4'b1010; ack_drv = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.push_back(4'b0010);
      tick(); #1;
      e = exp_q.pop_front();
      total++; if (a_grant !== e) begin bad++; $display("FAIL mrst_first got=%b exp=%b", a_grant, e); end
      m_cyc = '0; m_stb = '0;
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      clk = 1'b0; rst = 1'b1; sel_w = 1'b0;
      total = 0; bad = 0;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_sel = '1; m_cti = '0; m_bte = '0;
      ack_drv = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
      for (int i = 0; i < int'(NM); i++) begin
         m_adr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100;
         m_dat[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      end
      test_reset();
      test_single();
      test_round_robin();
      test_weighting();
      test_watchdog();
      test_collision();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/peripheral_qos_arbiter_wb.md
# peripheral_qos_arbiter_wb

Weighted round-robin Wishbone B3 arbiter that shares one slave port among NUM_MASTERS masters, with a per-master burst quota and a bus-hang watchdog. It sits between the master-side ports and the downstream peripheral_mux_wb, in the same clock domain; clock crossing is done upstream by peripheral_cdc_wb. Ownership is held for a whole Wishbone cycle (cyc high to cyc low). A stalled slave is terminated with an error response to the owning master.

## Interface
- NUM_MASTERS, 4: number of master ports, 2..8
- AW, 32: address width
- DW, 32: data width; select width is DW/8
- WEIGHTS, {4'd1,4'd1,4'd1,4'd1}: 4 bits per master, master 0 in LSBs; the number of consecutive bus cycles a master may win while it keeps requesting; a weight of 0 is treated as 1
- TIMEOUT, 255: stalled-strobe cycles before forced termination; 0 disables the watchdog

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous reset, active high
- wbm_adr_i / wbm_dat_i / wbm_sel_i  in  NUM_MASTERS*AW / NUM_MASTERS*DW / NUM_MASTERS*DW/8  packed master request fields
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master strobes
- wbm_cti_i / wbm_bte_i  in  NUM_MASTERS*3 / NUM_MASTERS*2  burst tags
- wbm_dat_o  out  DW  slave read data, broadcast to all masters
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses, owner bit only
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  slave-side copies
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  slave responses
- grant_o  out  NUM_MASTERS  one-hot owner, registered
- timeout_o  out  1  one-cycle pulse on watchdog termination

## Operation
- States: IDLE and BUSY.
- IDLE: if any wbm_cyc_i bit is set, pick a winner, register it into grant_o, and go to BUSY.
- Winner selection:
  - If the last owner is requesting and its credit is greater than 0, it wins again and its credit decrements.
  - Otherwise, scan round-robin starting at last owner + 1, modulo NUM_MASTERS. The first requester wins and its credit loads with weight − 1.
- BUSY: the owner's request fields route combinationally to the wbs_* outputs.
  - wbs_ack_i, wbs_err_i and wbs_rty_i route to the owner's bit only.
  - Non-owner response bits are held at 0.
- BUSY exits when the owner's wbm_cyc_i is low: grant_o clears and the state returns to IDLE. The last-owner register keeps that owner's index.
- Watchdog, counter width $clog2(TIMEOUT+1):
  - Counts BUSY cycles in which wbs_stb_o is high and ack, err and rty are all low.
  - Clears on any response and on leaving BUSY.
  - When the count reaches TIMEOUT, in that cycle: wbm_err_o is driven to the owner, wbs_cyc_o and wbs_stb_o are forced low, timeout_o = 1, and the counter clears.
- A master that is not granted sees no ack, err or rty. Its request stays pending.

## Timing
- Reset (asynchronous) values:
  - state IDLE, grant_o 0, timeout_o 0, all credits 0, watchdog counter 0.
  - Last owner = NUM_MASTERS−1, so master 0 wins first.
  - All wbs_* outputs are 0 and all wbm_ack_o/err_o/rty_o are 0. These follow grant_o combinationally, so they drop in the same instant as reset.
- Arbitration latency:
  - A request seen in IDLE at edge N gives grant_o at N+1.
  - wbs_cyc_o is high in the cycle after N+1's edge, i.e. one cycle of arbitration latency.
- Turnaround:
  - Owner cyc low at edge M gives IDLE at M+1. Re-arbitration happens at edge M+1, and the new grant is visible from M+2.
  - This one dead cycle is guaranteed between owners.
- Simultaneous events:
  - Ack in the same cycle the counter would reach TIMEOUT: the ack wins, with no err and no timeout_o.
  - Owner drops cyc in the same cycle as ack: the ack is delivered and the block is IDLE next cycle.
- Reset mid-cycle: the grant is lost immediately. On release of reset, arbitration restarts from master 0.
- Registered burst (cti=3'b010): the grant is held for the whole burst because cyc stays high. The watchdog counts stalled beats only.

## Test plan
- Single requester: master 2 asserts cyc/stb, and the slave acks 2 cycles later. Required: grant_o = 4'b0100 one cycle after the request, and wbm_ack_o = 4'b0100 in the ack cycle.
- Round-robin with all weights 1: all four masters request continuously, each with a single-beat cycle. Required: grant order 0, 1, 2, 3, 0, with exactly one idle cycle between grants.
- Weighting: WEIGHTS = {1,1,1,3}, masters 0 and 1 requesting continuously. Required: grant order 0, 0, 0, 1, 0, 0, 0, 1.
- Watchdog: TIMEOUT = 4 and the slave never responds. Required: after 4 stalled cycles, wbm_err_o is asserted on the owner's bit, timeout_o pulses once, and wbs_cyc_o is low in that cycle. When the master drops cyc, the next requester is granted.
- Collision: the ack arrives on the 4th stalled cycle with TIMEOUT = 4. Required: ack delivered, no err.
- Reset mid-transaction: assert wb_rst_i while master 1 owns the bus. Required: grant_o = 0 and wbs_cyc_o = 0 immediately. After release, with masters 1 and 3 requesting, master 1 wins first.
